// File: rtl/lamp_sqrt_ctrl.sv
// LAMP FPU sqrt / inverse-sqrt controller: classifies the operand, drives the significand core and packs the result.
// Build option LAMP_SQRT_SUBNORMAL_EN: normalise subnormal operands instead of flushing them to signed zero.

package lampFPU_pkg;
    localparam int LAMP_FLOAT_E_DW = 8;
    localparam int LAMP_FLOAT_F_DW = 7;
    localparam int LAMP_FLOAT_DW   = 1 + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;
    localparam int LAMP_FLOAT_BIAS = 127;
endpackage

module lamp_sqrt_ctrl
    import lampFPU_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [LAMP_FLOAT_DW-1:0]   op_i,
    input  logic                       inv_i,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [LAMP_FLOAT_DW-1:0]   res_o,
    output logic                       invalid_o,
    output logic                       divzero_o,
    output logic                       doSqrt_o,
    output logic [LAMP_FLOAT_F_DW:0]   s_o,
    output logic                       is_exp_odd_o,
    output logic                       invSqrt_o,
    output logic                       special_case_o,
    input  logic                       core_valid_i,
    input  logic [LAMP_FLOAT_F_DW:0]   core_res_i
);

    localparam int EW = LAMP_FLOAT_E_DW;
    localparam int FW = LAMP_FLOAT_F_DW;
    localparam int DW = LAMP_FLOAT_DW;
    localparam logic signed [EW+1:0] BIAS_S = (EW+2)'(LAMP_FLOAT_BIAS);
    localparam logic [DW-1:0] QNAN = 16'h7FC0;
    localparam logic [DW-1:0] PINF = 16'h7F80;

    // Handshakes: an operand transfers on a cycle with req_valid_i && req_ready_o;
    // a result transfers on a cycle with res_valid_o && res_ready_i, and res_o and
    // the flags stay fixed for as long as res_valid_o waits for res_ready_i.

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state_q, state_d;

    logic                   do_sqrt_q, do_sqrt_d;
    logic [FW:0]            s_q;
    logic                   exp_odd_q;
    logic                   inv_q;
    logic                   special_q;
    logic [EW-1:0]          exp_q;
    logic [DW-1:0]          spec_res_q;
    logic                   spec_invalid_q;
    logic                   spec_divzero_q;
    logic [DW-1:0]          res_q, res_d;
    logic                   invalid_q, invalid_d;
    logic                   divzero_q, divzero_d;

    logic                   accept;
    logic                   op_sign;
    logic [EW-1:0]          op_exp;
    logic [FW-1:0]          op_frac;

    logic                   is_nan;
    logic                   is_inf;
    logic                   is_zero;
    logic [FW:0]            cls_sig;
    logic signed [EW+1:0]   cls_e;
    logic signed [EW+1:0]   cls_k;
    logic [EW-1:0]          cls_exp_r;
    logic                   cls_special;
    logic [DW-1:0]          cls_res;
    logic                   cls_invalid;
    logic                   cls_divzero;

    assign op_sign = op_i[DW-1];
    assign op_exp  = op_i[DW-2:FW];
    assign op_frac = op_i[FW-1:0];
    assign accept  = (state_q == IDLE) && req_valid_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (core_valid_i) state_d = DONE;
            DONE:    if (res_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef LAMP_SQRT_SUBNORMAL_EN
    logic                   is_sub;
    logic [2:0]             sub_shift;
`endif

    always_comb begin
        is_nan  = (&op_exp) && (|op_frac);
        is_inf  = (&op_exp) && !(|op_frac);
        cls_sig = {1'b1, op_frac};
        cls_e   = $signed({2'b00, op_exp}) - BIAS_S;
`ifdef LAMP_SQRT_SUBNORMAL_EN
        is_zero   = !(|op_exp) && !(|op_frac);
        is_sub    = !(|op_exp) && (|op_frac);
        sub_shift = 3'd0;
        // Highest set fraction bit wins; the shift moves it into the hidden-bit slot.
        for (int i = 0; i < FW; i++) begin
            if (op_frac[i]) sub_shift = 3'(FW - i);
        end
        if (is_sub) begin
            cls_sig = {1'b0, op_frac} << sub_shift;
            cls_e   = -(EW+2)'(126) - $signed({7'd0, sub_shift});
        end
`else
        // Subnormals flush to a signed zero and take the zero path.
        is_zero = !(|op_exp);
`endif
        cls_k     = cls_e >>> 1;
        cls_exp_r = inv_i ? EW'(BIAS_S - cls_k) : EW'(cls_k + BIAS_S);

        cls_special = 1'b0;
        cls_res     = '0;
        cls_invalid = 1'b0;
        cls_divzero = 1'b0;
        if (is_nan) begin
            cls_special = 1'b1;
            cls_res     = QNAN;
        end else if (is_zero) begin
            cls_special = 1'b1;
            if (inv_i) begin
                cls_res     = {op_sign, PINF[DW-2:0]};
                cls_divzero = 1'b1;
            end else begin
                cls_res = {op_sign, {(DW-1){1'b0}}};
            end
        end else if (op_sign) begin
            cls_special = 1'b1;
            cls_res     = QNAN;
            cls_invalid = 1'b1;
        end else if (is_inf) begin
            cls_special = 1'b1;
            cls_res     = inv_i ? '0 : PINF;
        end
    end

    always_comb begin
        do_sqrt_d = accept;
        res_d     = res_q;
        invalid_d = invalid_q;
        divzero_d = divzero_q;
        if ((state_q == WAIT) && core_valid_i) begin
            if (special_q) begin
                res_d     = spec_res_q;
                invalid_d = spec_invalid_q;
                divzero_d = spec_divzero_q;
            end else begin
                invalid_d = 1'b0;
                divzero_d = 1'b0;
                // A core result below 1.0 loses one exponent step and shifts up by one.
                if (core_res_i[FW]) begin
                    res_d = {1'b0, exp_q, core_res_i[FW-1:0]};
                end else begin
                    res_d = {1'b0, exp_q - 8'd1, core_res_i[FW-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            do_sqrt_q      <= 1'b0;
            s_q            <= '0;
            exp_odd_q      <= 1'b0;
            inv_q          <= 1'b0;
            special_q      <= 1'b0;
            exp_q          <= '0;
            spec_res_q     <= '0;
            spec_invalid_q <= 1'b0;
            spec_divzero_q <= 1'b0;
            res_q          <= '0;
            invalid_q      <= 1'b0;
            divzero_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            do_sqrt_q <= do_sqrt_d;
            res_q     <= res_d;
            invalid_q <= invalid_d;
            divzero_q <= divzero_d;
            if (accept) begin
                s_q            <= cls_sig;
                exp_odd_q      <= cls_e[0];
                inv_q          <= inv_i;
                special_q      <= cls_special;
                exp_q          <= cls_exp_r;
                spec_res_q     <= cls_res;
                spec_invalid_q <= cls_invalid;
                spec_divzero_q <= cls_divzero;
            end
        end
    end

    assign req_ready_o    = (state_q == IDLE);
    assign res_valid_o    = (state_q == DONE);
    assign res_o          = res_q;
    assign invalid_o      = invalid_q;
    assign divzero_o      = divzero_q;
    assign doSqrt_o       = do_sqrt_q;
    assign s_o            = s_q;
    assign is_exp_odd_o   = exp_odd_q;
    assign invSqrt_o      = inv_q;
    assign special_case_o = special_q;

endmodule
